// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension arbiter: mode encodings,
// datapath widths and the packed result record held in the output slot.
package ext_pkg;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } ext_mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              src;
  } ext_result_t;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/response bundle between two immediate producers, the arbiter and
// the single downstream consumer.
interface imm_ext_arbiter_if;

  logic                      req0_valid;
  logic                      req0_ready;
  logic [ext_pkg::IMM_W-1:0] req0_imm;
  logic [1:0]                req0_mode;

  logic                      req1_valid;
  logic                      req1_ready;
  logic [ext_pkg::IMM_W-1:0] req1_imm;
  logic [1:0]                req1_mode;

  logic                       out_valid;
  logic                       out_ready;
  logic [ext_pkg::DATA_W-1:0] out_data;
  logic                       out_src;

  // Requesters and consumer side
  modport master (
    output req0_valid, req0_imm, req0_mode,
    input  req0_ready,
    output req1_valid, req1_imm, req1_mode,
    input  req1_ready,
    input  out_valid, out_data, out_src,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_imm, req0_mode,
    output req0_ready,
    input  req1_valid, req1_imm, req1_mode,
    output req1_ready,
    output out_valid, out_data, out_src,
    input  out_ready
  );

endinterface

// File: rtl/imm_ext_arbiter_extend_unit.sv
// Purely combinational immediate extender: widens a 16-bit immediate to
// 32 bits according to the selected extension mode.
module extend_unit
  import ext_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = '0;
    case (ext_mode_e'(mode))
      MODE_SIGN:   ext = {{16{imm[15]}}, imm};
      MODE_ZERO:   ext = {16'h0000, imm};
      MODE_UPPER:  ext = {imm, 16'h0000};
      MODE_BRANCH: ext = {{14{imm[15]}}, imm, 2'b00};
      default:     ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Two-requester arbiter feeding a shared immediate extender into a
// single-entry output register (round-robin or fixed priority).
module imm_ext_arbiter
  import ext_pkg::*;
#(
  parameter int PRIO_RESET = 0,
  parameter int FAIR       = 1
) (
  input  logic               clk,
  input  logic               reset,
  imm_ext_arbiter_if.slave   bus
);

  localparam logic PRIO_INIT = (PRIO_RESET != 0);
  localparam logic FAIR_EN   = (FAIR != 0);

  ext_result_t       out_q;
  logic              out_valid_q;
  logic              prio_q;

  logic              slot_free;
  logic              grant1;
  logic              xfer;
  logic [IMM_W-1:0]  sel_imm;
  logic [1:0]        sel_mode;
  logic [DATA_W-1:0] ext_data;

  // Slot is free when empty or being drained; reset holds both readies low
  // so no transfer can be signalled while the register is cleared.
  always_comb begin
    slot_free = reset & (~out_valid_q | bus.out_ready);
    if (bus.req0_valid & bus.req1_valid) begin
      grant1 = FAIR_EN & prio_q;
    end else begin
      grant1 = bus.req1_valid;
    end
    xfer     = slot_free & (bus.req0_valid | bus.req1_valid);
    sel_imm  = grant1 ? bus.req1_imm  : bus.req0_imm;
    sel_mode = grant1 ? bus.req1_mode : bus.req0_mode;
  end

  assign bus.req0_ready = slot_free & bus.req0_valid & ~grant1;
  assign bus.req1_ready = slot_free & bus.req1_valid &  grant1;

  extend_unit u_extend (
    .imm  (sel_imm),
    .mode (sel_mode),
    .ext  (ext_data)
  );

  // Output slot and priority pointer; a drain without a new transfer empties
  // the slot, while drain plus transfer simply overwrites it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      prio_q      <= PRIO_INIT;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_q.data  <= ext_data;
        out_q.src   <= grant1;
        if (FAIR_EN) begin
          prio_q <= ~grant1;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q.data;
  assign bus.out_src   = out_q.src;

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter PRIO_RESET, default 0, gives the requester that holds priority after reset (0 or 1).
REQ-002 Parameter FAIR, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with req0 always winning.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 presents an immediate.
REQ-006 req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-007 req0_imm  input  16  raw immediate from requester 0.
REQ-008 req0_mode  input  2  extension mode for requester 0.
REQ-009 req1_valid, req1_ready, req1_imm, req1_mode shall follow REQ-005..REQ-008 for requester 1.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  32  extended immediate.
REQ-013 out_src  output  1  index of the requester that produced out_data.

Function
REQ-014 Mode encoding: 00 sign-extend; 01 zero-extend; 10 upper, {imm,16'h0}; 11 branch offset, sign-extend then shift left 2.
REQ-015 A single-entry output register holds one result; the slot is free when out_valid=0 or when out_valid&out_ready.
REQ-016 reqN_ready shall be 1 only when the slot is free and N is granted; a transfer occurs on reqN_valid&reqN_ready.
REQ-017 Grant with one requester valid: that requester. Grant with both valid: the priority holder when FAIR=1, req0 when FAIR=0.
REQ-018 Grant is combinational from the valids, the priority, and slot state; readies are never both 1.
REQ-019 The priority holder shall change to the non-granted requester after each transfer when FAIR=1, and shall be unchanged when no transfer occurs.
REQ-020 Latency: a result is accepted in cycle t and shall appear with out_valid=1 and the correct out_src in cycle t+1.
REQ-021 Throughput: one result per cycle when out_ready is held at 1; drain and accept in the same cycle shall be supported.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_src shall be held stable and both readies shall be 0.
REQ-023 out_valid shall clear after a drain when no new transfer occurs in the same cycle.
REQ-024 reqN_imm and reqN_mode are sampled only on a transfer; changes at other times shall have no effect.

Reset
REQ-025 While reset=0: out_valid=0, out_data=32'h0, out_src=0, priority=PRIO_RESET, and req0_ready=req1_ready=0.
REQ-026 Reset asserted mid-operation shall discard any pending result immediately, without waiting for a clock edge.
REQ-027 Transfers shall be allowed from the first rising clk edge after reset deasserts.

Structure
REQ-028 Mode encodings (MODE_SIGN, MODE_ZERO, MODE_UPPER, MODE_BRANCH) shall live in the shared package ext_pkg.
REQ-029 Combinational extension shall be a sub-module extend_unit (16-bit imm and 2-bit mode in, 32-bit out), instantiated once after the grant mux.

Verification
REQ-030 req0 16'h8001, mode 00, out_ready=1 -> the next cycle has out_valid=1, out_data=32'hFFFF8001, out_src=0.
REQ-031 Modes on req1: 16'h8001/01 -> 32'h00008001; 16'h1234/10 -> 32'h12340000; 16'hFFFF/11 -> 32'hFFFFFFFC; out_src=1 in each case.
REQ-032 FAIR=1, PRIO_RESET=0, both valid for 6 cycles, out_ready=1 -> out_src sequence 0,1,0,1,0,1 with out_valid held at 1.
REQ-033 Result pending with out_ready=0 for 3 cycles -> both readies 0 and out_data unchanged; then out_ready=1 -> drain and new accept in the same cycle, next result in the following cycle.
REQ-034 reset driven low between clock edges while out_valid=1 -> out_valid=0 with no clock edge; after release with both valid, first out_src=PRIO_RESET.
REQ-035 FAIR=0, both valid for 4 cycles -> out_src=0 every cycle and req1_ready never 1.
